pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 256: payload width in bits (operands, PC, immediate, register tags packed by the caller).
REQ-002 Parameter CTRL_W, default 11: control-bundle width (EX, MEM and WB fields packed by the caller).
REQ-003 Parameter CNT_W, default 16: stall-counter width.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port in_valid  input  1: upstream stage presents a valid instruction.
REQ-007 Port in_ready  output  1: stage can accept an instruction this cycle.
REQ-008 Port in_data  input  DATA_W: upstream payload.
REQ-009 Port in_ctrl  input  CTRL_W: upstream control bundle.
REQ-010 Port out_valid  output  1: downstream copy holds a valid instruction.
REQ-011 Port out_ready  input  1: downstream stage accepts this cycle.
REQ-012 Port out_data  output  DATA_W: registered payload.
REQ-013 Port out_ctrl  output  CTRL_W: registered control bundle, forced to zero when out_valid=0.
REQ-014 Port flush  input  1: squash all held instructions (branch mispredict or exception).
REQ-015 Port occupancy  output  2: number of held instructions, 0 to 2.
REQ-016 Port stall_cnt  output  CNT_W: saturating count of back-pressured cycles.

Function
REQ-017 Storage: main register (main_v, main_data, main_ctrl) and skid register (skid_v, skid_data, skid_ctrl).
REQ-018 State machine: EMPTY (main_v=0, skid_v=0), FULL (main_v=1, skid_v=0), SKID (main_v=1, skid_v=1); no other encoding is reachable.
REQ-019 in_ready = !skid_v, registered; it never depends combinationally on out_ready.
REQ-020 A transfer in occurs when in_valid && in_ready; a transfer out occurs when out_valid && out_ready.
REQ-021 EMPTY with transfer in: main <- in, go to FULL. Latency in to out is exactly 1 cycle.
REQ-022 FULL with transfer out and transfer in: main <- in, stay in FULL. This sustains full throughput of 1 per cycle.
REQ-023 FULL with transfer out and no transfer in: go to EMPTY.
REQ-024 FULL with no transfer out and transfer in: skid <- in, go to SKID; main is unchanged.
REQ-025 FULL with neither transfer: hold.
REQ-026 SKID with transfer out: main <- skid, go to FULL. in_ready is 0 in SKID, so no transfer in is possible.
REQ-027 SKID with no transfer out: hold all state.
REQ-028 Ordering: instructions leave in acceptance order; none is dropped or duplicated except by flush.
REQ-029 out_valid = main_v. out_data = main_data. out_ctrl = main_v ? main_ctrl : 0.
REQ-030 Flush has priority over all transitions: next state is EMPTY, and any same-cycle transfer in or out is discarded. Data registers may retain stale payload, but out_ctrl reads 0.
REQ-031 in_ready is 1 in the cycle after a flush.
REQ-032 occupancy = main_v + skid_v.
REQ-033 stall_cnt increments by 1 each cycle with out_valid && !out_ready, saturates at all-ones, and is not cleared by flush.
REQ-034 Data and control registers load only on the transfers listed above; there are no other enables.

Reset
REQ-035 While rst=0, asynchronously: main_v=0, skid_v=0, state EMPTY, all data and control registers 0, stall_cnt=0.
REQ-036 Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_ctrl=0, occupancy=0.
REQ-037 Reset deassertion is synchronous to clk. The first transfer is accepted on the first rising edge with rst=1.
REQ-038 Reset asserted mid-operation discards all held instructions immediately, without waiting for a clock edge.

Verification
REQ-039 Streaming: out_ready=1, in_valid=1 for 8 cycles with in_data=0..7 -> out_data=0..7 on consecutive cycles starting 1 cycle later; stall_cnt=0.
REQ-040 Back-pressure: load A, then hold out_ready=0 while presenting B and C -> B goes to skid, in_ready=0, C is held upstream, occupancy=2. Then out_ready=1 -> outputs are A, B, C in order; stall_cnt equals the number of stalled cycles.
REQ-041 Flush in SKID: occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and the input presented during flush never appears at the output.
REQ-042 Mid-operation reset: occupancy=2, drive rst=0 between clock edges -> out_valid=0, out_ctrl=0, in_ready=1 before the next edge; stall_cnt=0.
REQ-043 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-044 Random valid/ready on both sides for 10,000 cycles, checked against a scoreboard -> ordering preserved, nothing lost, occupancy never exceeds 2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: one main register plus one skid register, so the
// upstream ready is registered and never depends on the downstream ready.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    stall_q, stall_d;

  logic main_v, skid_v;
  logic xfer_in, xfer_out;
  logic main_load_in, main_load_skid, skid_load;

  assign main_v   = (state_q != EMPTY);
  assign skid_v   = (state_q == SKID);
  assign xfer_in  = in_valid && in_ready_q;
  assign xfer_out = main_v && out_ready;

  // Flush overrides every transition; loads are suppressed so only the
  // valid bits clear and the stale payload is masked at the output.
  always_comb begin
    state_d        = state_q;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_load_in = 1'b1;
            state_d      = FULL;
          end
        end
        FULL: begin
          case ({xfer_out, xfer_in})
            2'b11: main_load_in = 1'b1;
            2'b10: state_d = EMPTY;
            2'b01: begin
              skid_load = 1'b1;
              state_d   = SKID;
            end
            default: state_d = FULL;
          endcase
        end
        SKID: begin
          if (xfer_out) begin
            main_load_skid = 1'b1;
            state_d        = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (main_load_in) begin
      main_data_d = in_data;
      main_ctrl_d = in_ctrl;
    end else if (main_load_skid) begin
      main_data_d = skid_data_q;
      main_ctrl_d = skid_ctrl_q;
    end
    if (skid_load) begin
      skid_data_d = in_data;
      skid_ctrl_d = in_ctrl;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (main_v && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != SKID);
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_v ? main_ctrl_q : '0;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic, all
// checked against a FIFO-of-depth-2 reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 11;
  localparam int unsigned NW = 4;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } entry_t;

  entry_t      mq[$];
  int unsigned m_stall;
  int unsigned n_vec, n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic          ev;
    logic [CW-1:0] ec;
    ev = (mq.size() > 0);
    ec = ev ? mq[0].ctrl : '0;
    check_eq("out_valid", 64'(out_valid), 64'(ev));
    check_eq("out_ctrl", 64'(out_ctrl), 64'(ec));
    if (ev) check_eq("out_data", 64'(out_data), 64'(mq[0].data));
    check_eq("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    check_eq("occupancy", 64'(occupancy), 64'(mq.size()));
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
  endtask

  // Drive one cycle's inputs, advance the model, then check after the edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    bit xin, xout;
    entry_t e;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    xin  = iv && (mq.size() < 2);
    xout = (mq.size() > 0) && ordy;
    if ((mq.size() > 0) && !ordy && (m_stall < (1 << NW) - 1)) m_stall++;
    if (fl) begin
      mq.delete();
    end else begin
      if (xout) void'(mq.pop_front());
      if (xin) begin
        e.data = d;
        e.ctrl = c;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_stall = 0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    in_valid = 0; in_data = '0; in_ctrl = '0; out_ready = 0; flush = 0;
    m_stall = 0;
    do_reset();
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);

    // Streaming 0..7 at full rate
    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i), CW'(i + 1), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("stream_stall", 64'(stall_cnt), 64'd0);

    // Back-pressure: A into main, B into skid, C held upstream
    do_reset();
    cycle(1'b1, 32'hA, 11'h0A, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 11'h0B, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 11'h0C, 1'b0, 1'b0);
    check_eq("bp_occupancy", 64'(occupancy), 64'd2);
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    cycle(1'b1, 32'hC, 11'h0C, 1'b0, 1'b0);
    check_eq("bp_stall", 64'(stall_cnt), 64'd3);
    cycle(1'b1, 32'hC, 11'h0C, 1'b1, 1'b0);
    check_eq("bp_out_B", 64'(out_data), 64'hB);
    cycle(1'b1, 32'hC, 11'h0C, 1'b1, 1'b0);
    check_eq("bp_out_C", 64'(out_data), 64'hC);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush while in SKID, with a new input presented in the same cycle
    cycle(1'b1, 32'h11, 11'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 11'h22, 1'b0, 1'b0);
    check_eq("fl_occ_before", 64'(occupancy), 64'd2);
    cycle(1'b1, 32'h33, 11'h33, 1'b0, 1'b1);
    check_eq("fl_out_valid", 64'(out_valid), 64'd0);
    check_eq("fl_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("fl_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    check_eq("fl_no_ghost", 64'(out_valid), 64'd0);

    // Mid-operation asynchronous reset with two instructions held
    cycle(1'b1, 32'h44, 11'h44, 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 11'h55, 1'b0, 1'b0);
    check_eq("mr_occ_before", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("mr_out_valid", 64'(out_valid), 64'd0);
    check_eq("mr_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("mr_in_ready", 64'(in_ready), 64'd1);
    check_eq("mr_occupancy", 64'(occupancy), 64'd0);
    check_eq("mr_stall", 64'(stall_cnt), 64'd0);
    mq.delete();
    m_stall = 0;
    @(negedge clk);
    rst = 1'b1;

    // Stall counter saturation
    cycle(1'b1, 32'h66, 11'h66, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("sat_stall", 64'(stall_cnt), 64'd15);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check_eq("sat_after_flush", 64'(stall_cnt), 64'd15);

    // Random traffic
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), DW'($urandom), CW'($urandom_range(0, 2047)),
            1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 199) == 0));
      if (occupancy > 2'd2) check_eq("rand_occ_max", 64'(occupancy), 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
